// File: rtl/key_pkg.sv
// Shared types and helpers for the key one-hot latch.
// Key width, FSM states and popcount classification.
package key_pkg;

    localparam int KEY_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_REL
    } key_state_t;

    typedef enum logic [1:0] {
        POP_ZERO,
        POP_ONE,
        POP_MULTI
    } pop_class_t;

    // Classify a key vector as none, exactly one, or several keys down
    function automatic pop_class_t onehot_count(input logic [KEY_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < KEY_W; i++) begin
            n = n + int'(v[i]);
        end
        if (n == 0) begin
            return POP_ZERO;
        end else if (n == 1) begin
            return POP_ONE;
        end else begin
            return POP_MULTI;
        end
    endfunction

endpackage

// File: rtl/key_onehot_latch_if.sv
// Key input / one-hot token bundle.
// master = latch side, slave = keypad + consumer side.
import key_pkg::*;

interface key_onehot_latch_if;

    logic [KEY_W-1:0] key_raw;
    logic             ack;
    logic [KEY_W-1:0] data;
    logic             valid;
    logic             multi_err;

    modport master (
        input  key_raw,
        input  ack,
        output data,
        output valid,
        output multi_err
    );

    modport slave (
        output key_raw,
        output ack,
        input  data,
        input  valid,
        input  multi_err
    );

endinterface

// File: rtl/key_debounce.sv
// Single-key 2-flop synchroniser plus debounce.
// Level flips after DB_CYCLES consecutive differing cycles.
import key_pkg::*;

module key_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_d
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          lvl_q;
    logic          lvl_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count differing cycles; any agreeing cycle restarts the count
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (s2_q != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, stable level and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= key_raw;
            s2_q  <= s1_q;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    assign key_d = lvl_q;

endmodule

// File: rtl/key_onehot_latch.sv
// Debounced single-key press latch with valid/ack handshake.
// Multi-key presses are flagged and produce no token.
import key_pkg::*;

module key_onehot_latch #(
    parameter int DB_CYCLES = 4
) (
    input logic                clk,
    input logic                rst_n,
    key_onehot_latch_if.master bus
);

    logic [KEY_W-1:0] key_d;
    key_state_t       state_q;
    logic [KEY_W-1:0] data_q;
    logic             valid_q;
    logic             err_q;

    for (genvar i = 0; i < KEY_W; i++) begin : g_db
        key_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .key_raw(bus.key_raw[i]),
            .key_d  (key_d[i])
        );
    end

    // Token FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    unique case (onehot_count(key_d))
                        POP_ONE: begin
                            data_q  <= key_d;
                            valid_q <= 1'b1;
                            state_q <= HOLD;
                        end
                        POP_MULTI: begin
                            err_q   <= 1'b1;
                            state_q <= WAIT_REL;
                        end
                        default: ;
                    endcase
                end
                HOLD: begin
                    if (bus.ack) begin
                        data_q  <= '0;
                        valid_q <= 1'b0;
                        state_q <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (key_d == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.multi_err = err_q;

endmodule
